sample_packetizer: RTL and testbench
====================================

Name: sample_packetizer

Overview:
Packs multi-channel ADC sample sets, captured on the master clock, into fixed-length Avalon-ST packets for the Ethernet MAC transmit path. It sits directly upstream of the MAC TX stream input. A set-wide FIFO absorbs MAC back-pressure. A packet starts only when a full packet's worth of data is buffered, so the MAC never sees a mid-packet underrun.

Parameters:
NUM_CH, 4, channels per sample set
SAMPLE_W, 16, bits per channel sample; NUM_CH*SAMPLE_W must be a multiple of 32
SETS_PER_PKT, 64, sample sets per packet payload (>=1)
FIFO_DEPTH, 256, FIFO depth in sample sets; power of 2, >= SETS_PER_PKT

Ports:
mclk_i_clk  input  1  master clock; all logic on rising edge
mclk_reset_reset_n  input  1  asynchronous active-low reset
enable  input  1  capture enable; 0 = incoming sets ignored (not counted as drops)
sample_valid  input  1  one-cycle strobe: sample_data holds a complete set
sample_data  input  NUM_CH*SAMPLE_W  channel 0 in LSBs
out_data  output  32  Avalon-ST data word
out_valid  output  1  word valid
out_ready  input  1  sink ready; readyLatency 0
out_sop  output  1  first word of packet
out_eop  output  1  last word of packet
overflow_count  output  16  saturating count of dropped sets
fifo_level  output  $clog2(FIFO_DEPTH)+1  sets currently buffered

Behaviour:
- Reset (async assert, release synchronous to mclk_i_clk): out_valid=0, out_sop=0, out_eop=0, out_data=0, overflow_count=0, fifo_level=0, seq=0, FSM=IDLE, FIFO empty.
- Capture: sample_valid&&enable&&!full -> write set (level +1 next cycle). sample_valid&&enable&&full -> drop the set; overflow_count +1, saturating at 0xFFFF.
- Simultaneous write and read of the FIFO in one cycle is legal; level is unchanged.
- WPS = NUM_CH*SAMPLE_W/32 words per set; set words are emitted lowest 32 bits first.
- FSM IDLE: when level >= SETS_PER_PKT, go to HDR (transition regardless of enable).
- FSM HDR: out_data={16'hA55A, seq}, out_sop=1. On accept, go to TS if the optional feature is compiled in, else to DATA.
- FSM DATA: emit SETS_PER_PKT*WPS words, popping one set after its last word is accepted. out_eop=1 on the final word. On accept of the final word: seq+1 (wraps 0xFFFF->0), go to IDLE.
- Packet length = 1 + SETS_PER_PKT*WPS words (+1 with timestamp).
- Output is registered. While out_valid&&!out_ready, out_data, out_sop and out_eop hold stable. A word is accepted when out_valid&&out_ready.
- out_valid stays high for the whole packet (guaranteed by the start threshold). Minimum 1 idle cycle between packets.
- enable deassert mid-packet: the current packet completes normally; partial residue stays buffered until more data arrives.
- No mid-packet abort except reset. Reset mid-packet truncates the packet; the sink is responsible for discarding it.

Optional Feature:
SAMPLE_PKT_TIMESTAMP_EN:
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) exists. It is latched on the cycle FSM leaves IDLE. That latched value is sent as a TS word immediately after the header, before any data. Packet length grows by 1.
- Undefined: no counter and no TS state; HDR goes directly to DATA.

Decomposition:
- Package wiphase_pkt_pkg: PKT_MAGIC=16'hA55A, FSM state enum {IDLE,HDR,TS,DATA}, WPS helper function.
- Sub-module sample_set_fifo: synchronous FIFO, width NUM_CH*SAMPLE_W, depth FIFO_DEPTH, outputs full/empty/level. Same clock and reset.

Test Plan:
- Defaults, out_ready=1, 64 valid sets with ch=i counting values -> one packet of 129 words. Word0=0xA55A0000 with sop. Word1={ch1,ch0} of set 0. Word128 has eop. No gaps.
- 128 sets, out_ready=1 -> two packets with headers 0xA55A0000 then 0xA55A0001. Force seq=0xFFFF -> next header seq=0x0000.
- Random out_ready 30% duty -> data/sop/eop stable while stalled. Payload matches a scoreboard. out_valid never drops mid-packet.
- out_ready=0, 300 sets at enable=1 -> fifo_level=256, overflow_count=44. 0x10000+ drops -> overflow_count holds 0xFFFF.
- 63 sets, then enable=0 -> no packet emitted, fifo_level=63. Enable=1 plus 1 set -> packet emitted.
- Assert reset mid-packet -> outputs 0 asynchronously; seq restarts at 0. With SAMPLE_PKT_TIMESTAMP_EN -> word1 = counter at packet start; packet length 130.

Source files
------------

// File: rtl/wiphase_pkt_pkg.sv
// Shared constants, FSM state type and sizing helper for the sample packetizer.
package wiphase_pkt_pkg;

  localparam logic [15:0] PKT_MAGIC = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    TS   = 2'd2,
    DATA = 2'd3
  } pkt_state_t;

  // 32-bit stream words needed to carry one sample set.
  function automatic int words_per_set(input int num_ch, input int sample_w);
    return (num_ch * sample_w) / 32;
  endfunction

endpackage

// File: rtl/sample_set_fifo.sv
// Synchronous sample-set FIFO. next_data shows the set that will sit at the head
// once this cycle's pop (if any) has taken effect, so the reader can chain sets gap-free.
module sample_set_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         next_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_addr;
  logic [LW-1:0]    level_reg;

  assign rd_addr   = rd_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign next_data = mem[rd_addr];
  assign level     = level_reg;
  assign full      = (level_reg == LW'(DEPTH));
  assign empty     = (level_reg == '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/sample_packetizer.sv
// Packs ADC sample sets into fixed-length Avalon-ST packets for the MAC TX path.
// Define SAMPLE_PKT_TIMESTAMP_EN to insert a cycle-count timestamp word after the header.
module sample_packetizer
  import wiphase_pkt_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_W     = 16,
  parameter int SETS_PER_PKT = 64,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic                             mclk_i_clk,
  input  logic                             mclk_reset_reset_n,
  input  logic                             enable,
  input  logic                             sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]       sample_data,
  output logic [31:0]                      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [15:0]                      overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int SET_W     = NUM_CH * SAMPLE_W;
  localparam int WPS       = words_per_set(NUM_CH, SAMPLE_W);
  localparam int LW        = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW       = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int SCW       = (SETS_PER_PKT > 1) ? $clog2(SETS_PER_PKT) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WPS - 1);
  localparam logic [SCW-1:0] LAST_SET  = SCW'(SETS_PER_PKT - 1);

  pkt_state_t       state_reg, state_next;
  logic [31:0]      out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_sop_reg, out_sop_next;
  logic             out_eop_reg, out_eop_next;
  logic [WCW-1:0]   word_idx_reg, word_idx_next;
  logic [SCW-1:0]   set_idx_reg, set_idx_next;
  logic [15:0]      seq_reg, seq_next;
  logic [15:0]      overflow_reg;
  logic             load_word, pop, accept, wr_en, full, empty;
  logic [SET_W-1:0] head_set;
  logic [31:0]      set_words [WPS];

  sample_set_fifo #(.WIDTH(SET_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (mclk_i_clk),
    .rst_n     (mclk_reset_reset_n),
    .wr_en     (wr_en),
    .wr_data   (sample_data),
    .rd_en     (pop && !empty),
    .next_data (head_set),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WPS; gi++) begin : g_words
      assign set_words[gi] = head_set[gi*32 +: 32];
    end
  endgenerate

  assign wr_en  = sample_valid && enable && !full;
  assign accept = out_valid_reg && out_ready;

`ifdef SAMPLE_PKT_TIMESTAMP_EN
  logic [31:0] cycle_cnt_reg, ts_reg;
  always_ff @(posedge mclk_i_clk or negedge mclk_reset_reset_n) begin
    if (!mclk_reset_reset_n) begin
      cycle_cnt_reg <= '0;
      ts_reg        <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_reg == IDLE && state_next != IDLE) ts_reg <= cycle_cnt_reg;
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_sop_next   = out_sop_reg;
    word_idx_next  = word_idx_reg;
    set_idx_next   = set_idx_reg;
    seq_next       = seq_reg;
    load_word      = 1'b0;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_level >= LW'(SETS_PER_PKT)) begin
          state_next     = HDR;
          out_valid_next = 1'b1;
          out_sop_next   = 1'b1;
          out_data_next  = {PKT_MAGIC, seq_reg};
        end
      end
      HDR: begin
        if (accept) begin
          out_sop_next = 1'b0;
`ifdef SAMPLE_PKT_TIMESTAMP_EN
          state_next    = TS;
          out_data_next = ts_reg;
`else
          state_next    = DATA;
          word_idx_next = '0;
          set_idx_next  = '0;
          load_word     = 1'b1;
`endif
        end
      end
`ifdef SAMPLE_PKT_TIMESTAMP_EN
      TS: begin
        if (accept) begin
          state_next    = DATA;
          word_idx_next = '0;
          set_idx_next  = '0;
          load_word     = 1'b1;
        end
      end
`endif
      DATA: begin
        if (accept) begin
          if (word_idx_reg == LAST_WORD) begin
            pop = 1'b1;
            if (set_idx_reg == LAST_SET) begin
              state_next     = IDLE;
              out_valid_next = 1'b0;
              out_data_next  = '0;
              seq_next       = seq_reg + 16'd1;
            end else begin
              set_idx_next  = set_idx_reg + SCW'(1);
              word_idx_next = '0;
              load_word     = 1'b1;
            end
          end else begin
            word_idx_next = word_idx_reg + WCW'(1);
            load_word     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // head_set already reflects this cycle's pop, so word 0 of the next set is ready.
    if (load_word) out_data_next = set_words[word_idx_next];
    out_eop_next = (state_next == DATA) && (set_idx_next == LAST_SET) &&
                   (word_idx_next == LAST_WORD);
  end

  always_ff @(posedge mclk_i_clk or negedge mclk_reset_reset_n) begin
    if (!mclk_reset_reset_n) begin
      state_reg     <= IDLE;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      word_idx_reg  <= '0;
      set_idx_reg   <= '0;
      seq_reg       <= '0;
      overflow_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_sop_reg   <= out_sop_next;
      out_eop_reg   <= out_eop_next;
      word_idx_reg  <= word_idx_next;
      set_idx_reg   <= set_idx_next;
      seq_reg       <= seq_next;
      if (sample_valid && enable && full && overflow_reg != 16'hFFFF)
        overflow_reg <= overflow_reg + 16'd1;
    end
  end

  assign out_data       = out_data_reg;
  assign out_valid      = out_valid_reg;
  assign out_sop        = out_sop_reg;
  assign out_eop        = out_eop_reg;
  assign overflow_count = overflow_reg;

endmodule

// File: tb/tb_sample_packetizer.sv
// Self-checking bench for sample_packetizer: table-driven packet scenarios plus
// hand-written overflow, enable-gating and mid-packet reset sequences.
module tb_sample_packetizer;

  localparam int NUM_CH = 4;
  localparam int SAMPLE_W = 16;
  localparam int SETS = 64;
  localparam int DEPTH = 256;
  localparam int WPS = 2;
`ifdef SAMPLE_PKT_TIMESTAMP_EN
  localparam int TSW = 1;
`else
  localparam int TSW = 0;
`endif
  localparam int PKT_LEN = 1 + TSW + SETS * WPS;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sample_valid;
  logic [63:0] sample_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] overflow_count;
  logic [8:0]  fifo_level;

  sample_packetizer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .SETS_PER_PKT(SETS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .mclk_i_clk         (clk),
    .mclk_reset_reset_n (rst_n),
    .enable             (enable),
    .sample_valid       (sample_valid),
    .sample_data        (sample_data),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_sop            (out_sop),
    .out_eop            (out_eop),
    .overflow_count     (overflow_count),
    .fifo_level         (fifo_level)
  );

  typedef struct {
    int n_sets;
    int ready_pct;
    int exp_pkts;
    int exp_level;
  } vec_t;

  int          checks;
  int          errors;
  logic [31:0] sb [$];
  int          pos;
  int          pkt_count;
  logic [15:0] exp_seq;
  int          ready_pct;
  int          set_idx;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_sop;
  logic        prev_eop;
  vec_t        vecs [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Output monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (!rst_n) begin
      pos        = 0;
      exp_seq    = '0;
      pkt_count  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_sop", 32'(out_sop), 32'(prev_sop));
        check("stall_eop", 32'(out_eop), 32'(prev_eop));
      end else if (pos > 0) begin
        check("valid_gap", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (pos == 0) begin
          check("hdr_data", out_data, {16'hA55A, exp_seq});
          check("hdr_sop", 32'(out_sop), 32'd1);
          check("hdr_eop", 32'(out_eop), 32'd0);
        end else if (pos <= TSW) begin
          check("ts_sop", 32'(out_sop), 32'd0);
          check("ts_eop", 32'(out_eop), 32'd0);
        end else begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got 0x%08h expected no word at %0t", out_data, $time);
          end else begin
            exp_w = sb.pop_front();
            check("payload", out_data, exp_w);
          end
          check("data_sop", 32'(out_sop), 32'd0);
          check("data_eop", 32'(out_eop), 32'(pos == PKT_LEN - 1));
        end
        pos++;
        if (pos == PKT_LEN) begin
          pos = 0;
          exp_seq++;
          pkt_count++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sop   = out_sop;
      prev_eop   = out_eop;
    end
  end

  function automatic logic [63:0] make_set(input int k);
    logic [63:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*16 +: 16] = 16'(k * 4 + c);
    return d;
  endfunction

  // Asserts reset between clock edges and checks the outputs clear immediately.
  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sop", 32'(out_sop), 32'd0);
    check("rst_eop", 32'(out_eop), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow_count), 32'd0);
    repeat (3) @(negedge clk);
    sb.delete();
    set_idx = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_sets(input int n, input logic en, input int push_limit);
    logic [63:0] d;
    int pushed;
    pushed = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      d            = make_set(set_idx);
      sample_valid = 1'b1;
      enable       = en;
      sample_data  = d;
      if (en && pushed < push_limit) begin
        sb.push_back(d[31:0]);
        sb.push_back(d[63:32]);
        pushed++;
      end
      set_idx++;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_pkts(input string name, input int n, input int limit);
    int c;
    c = 0;
    while (pkt_count < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(pkt_count), 32'(n));
  endtask

  initial begin
    int c;
    rst_n        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    out_ready    = 1'b0;
    ready_pct    = 100;
    checks       = 0;
    errors       = 0;
    set_idx      = 0;
    pos          = 0;
    pkt_count    = 0;
    exp_seq      = '0;
    prev_stall   = 1'b0;

    vecs[0] = '{n_sets: 64,  ready_pct: 100, exp_pkts: 1, exp_level: 0};
    vecs[1] = '{n_sets: 128, ready_pct: 100, exp_pkts: 2, exp_level: 0};
    vecs[2] = '{n_sets: 130, ready_pct: 30,  exp_pkts: 2, exp_level: 2};
    vecs[3] = '{n_sets: 200, ready_pct: 60,  exp_pkts: 3, exp_level: 8};

    for (int r = 0; r < 4; r++) begin
      ready_pct = 0;
      reset_dut();
      ready_pct = vecs[r].ready_pct;
      send_sets(vecs[r].n_sets, 1'b1, vecs[r].n_sets);
      wait_pkts("row_pkts", vecs[r].exp_pkts, 6000);
      repeat (200) @(negedge clk);
      check("row_pkts_final", 32'(pkt_count), 32'(vecs[r].exp_pkts));
      check("row_level", 32'(fifo_level), 32'(vecs[r].exp_level));
      check("row_idle_valid", 32'(out_valid), 32'd0);
      check("row_ovf", 32'(overflow_count), 32'd0);
      $display("row %0d: %0d sets, ready %0d%%, %0d packets, level %0d", r,
               vecs[r].n_sets, vecs[r].ready_pct, pkt_count, fifo_level);
    end

    // One set short of a packet, then sets while disabled: nothing may move.
    ready_pct = 100;
    reset_dut();
    send_sets(63, 1'b1, 63);
    send_sets(10, 1'b0, 0);
    repeat (100) @(negedge clk);
    check("partial_pkts", 32'(pkt_count), 32'd0);
    check("partial_level", 32'(fifo_level), 32'd63);
    check("partial_ovf", 32'(overflow_count), 32'd0);
    check("partial_valid", 32'(out_valid), 32'd0);
    send_sets(1, 1'b1, 1);
    wait_pkts("partial_done", 1, 1000);
    repeat (5) @(negedge clk);
    check("partial_level_after", 32'(fifo_level), 32'd0);
    $display("enable gating: packets %0d level %0d", pkt_count, fifo_level);

    // Back-pressure: fill the FIFO, count drops, then saturate the counter.
    ready_pct = 0;
    reset_dut();
    send_sets(300, 1'b1, 256);
    repeat (3) @(negedge clk);
    check("ovf_level", 32'(fifo_level), 32'd256);
    check("ovf_count", 32'(overflow_count), 32'd44);
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    check("ovf_hold_hdr", out_data, 32'hA55A0000);
    send_sets(65536, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("ovf_saturate", 32'(overflow_count), 32'h0000FFFF);
    ready_pct = 100;
    wait_pkts("ovf_drain", 4, 4000);
    repeat (5) @(negedge clk);
    check("ovf_drain_level", 32'(fifo_level), 32'd0);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);
    $display("overflow: count 0x%04h, drained %0d packets", overflow_count, pkt_count);

    // Reset in the middle of a stalled packet; the next packet restarts at seq 0.
    ready_pct = 0;
    reset_dut();
    ready_pct = 30;
    send_sets(64, 1'b1, 64);
    c = 0;
    while (pos < 10 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("midpkt_reached", 32'(pos >= 10), 32'd1);
    ready_pct = 0;
    reset_dut();
    ready_pct = 100;
    send_sets(64, 1'b1, 64);
    wait_pkts("after_reset_pkt", 1, 1000);
    repeat (5) @(negedge clk);
    check("after_reset_level", 32'(fifo_level), 32'd0);
    $display("mid-packet reset: packets after restart %0d", pkt_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
